// File: rtl/arb_req_ctrl.sv
// Requester-side controller for a 3-channel fixed-priority, edge-detecting
// arbiter. Each channel queues jobs, raises a fresh request edge per job,
// waits for the matching grant pulse and retries after a timeout. A job is
// discarded once its retries run out.

module arb_req_chan #(
  parameter int TIMEOUT   = 4,
  parameter int MAX_RETRY = 3,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job_i,
  input  logic              a_i,
  output logic              r_o,
  output logic              done_o,
  output logic              err_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              busy_o,
  output logic              ovf_o
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} st_e;

  st_e               state_q, state_d;
  logic              r_q, r_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              in_req, timeout, dec;

  assign in_req  = (state_q == S_REQ);
  assign timeout = in_req && (timer_q == TW'(TIMEOUT - 1));

  // State and registered outputs; reset drops r at once and forgets queued jobs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Next state: grant beats timeout; GAP always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pend_q != '0) state_d = S_REQ;
      S_REQ:   if (a_i || timeout) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, timer, retry count and pend counter
  always_comb begin
    r_d     = (state_d == S_REQ);
    done_d  = in_req && a_i;
    err_d   = timeout && !a_i && (retry_q == RW'(MAX_RETRY));
    dec     = done_d || err_d;
    timer_d = (in_req && !a_i && !timeout) ? timer_q + 1'b1 : '0;
    retry_d = retry_q;
    if (dec)                    retry_d = '0;
    else if (timeout && !a_i)   retry_d = retry_q + 1'b1;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (job_i && !dec) begin
      if (&pend_q) ovf_d  = 1'b1;
      else         pend_d = pend_q + 1'b1;
    end else if (!job_i && dec) begin
      pend_d = pend_q - 1'b1;
    end
  end

  assign r_o    = r_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q != S_IDLE) || (pend_q != '0);
endmodule

module arb_req_ctrl #(
  parameter int TIMEOUT   = 4,
  parameter int MAX_RETRY = 3,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job1,
  input  logic              job2,
  input  logic              job3,
  input  logic              a1,
  input  logic              a2,
  input  logic              a3,
  output logic              r1,
  output logic              r2,
  output logic              r3,
  output logic              done1,
  output logic              done2,
  output logic              done3,
  output logic              err1,
  output logic              err2,
  output logic              err3,
  output logic [PEND_W-1:0] pend1,
  output logic [PEND_W-1:0] pend2,
  output logic [PEND_W-1:0] pend3,
  output logic              busy,
  output logic              ovf
);
  localparam int NCH = 3;

  logic [NCH-1:0]             job_v, a_v, r_v, done_v, err_v, busy_v, ovf_v;
  logic [NCH-1:0][PEND_W-1:0] pend_v;

  assign job_v = {job3, job2, job1};
  assign a_v   = {a3, a2, a1};

  // Channels are fully independent; priority is resolved by the arbiter
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    arb_req_chan #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .PEND_W(PEND_W)) u_ch (
      .clk    (clk),
      .rstn   (rstn),
      .job_i  (job_v[g]),
      .a_i    (a_v[g]),
      .r_o    (r_v[g]),
      .done_o (done_v[g]),
      .err_o  (err_v[g]),
      .pend_o (pend_v[g]),
      .busy_o (busy_v[g]),
      .ovf_o  (ovf_v[g])
    );
  end

  assign {r3, r2, r1}          = r_v;
  assign {done3, done2, done1} = done_v;
  assign {err3, err2, err1}    = err_v;
  assign pend1 = pend_v[0];
  assign pend2 = pend_v[1];
  assign pend3 = pend_v[2];
  assign busy  = |busy_v;
  assign ovf   = |ovf_v;
endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: fixed vector table, directed multi-cycle scenarios
// and randomized traffic, all compared against a cycle-count reference model.
`timescale 1ns/1ps
module tb_arb_req_ctrl;
  localparam int TIMEOUT = 4, MAX_RETRY = 3, PEND_W = 4;
  localparam int PMAX = (1 << PEND_W) - 1;

  logic clk = 1'b0, rstn;
  logic job1, job2, job3, a1, a2, a3;
  logic r1, r2, r3, done1, done2, done3, err1, err2, err3, busy, ovf;
  logic [PEND_W-1:0] pend1, pend2, pend3;

  always #5 clk = ~clk;

  arb_req_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .PEND_W(PEND_W)) dut (
    .clk(clk), .rstn(rstn), .job1(job1), .job2(job2), .job3(job3),
    .a1(a1), .a2(a2), .a3(a3), .r1(r1), .r2(r2), .r3(r3),
    .done1(done1), .done2(done2), .done3(done3), .err1(err1), .err2(err2), .err3(err3),
    .pend1(pend1), .pend2(pend2), .pend3(pend3), .busy(busy), .ovf(ovf));

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a request window is tracked by its age in cycles, and
  // the earliest cycle a new window may open is kept as an absolute time.
  int m_t, m_pend[3], m_age[3], m_tries[3], m_ready[3];
  bit m_done[3], m_err[3], m_ovf;

  function automatic void model_reset();
    m_t = 0; m_ovf = 0;
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = 0; m_age[c] = -1; m_tries[c] = 0; m_ready[c] = 0;
      m_done[c] = 0; m_err[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit [2:0] j, input bit [2:0] a);
    m_t++;
    for (int c = 0; c < 3; c++) begin
      bit dec;
      dec = 0; m_done[c] = 0; m_err[c] = 0;
      if (m_age[c] >= 0) begin
        if (a[c]) begin
          m_done[c] = 1; dec = 1; m_tries[c] = 0; m_age[c] = -1; m_ready[c] = m_t + 2;
        end else if (m_age[c] == TIMEOUT - 1) begin
          m_age[c] = -1; m_ready[c] = m_t + 2;
          if (m_tries[c] == MAX_RETRY) begin
            m_err[c] = 1; dec = 1; m_tries[c] = 0;
          end else m_tries[c]++;
        end else m_age[c]++;
      end else if (m_t >= m_ready[c] && m_pend[c] > 0) begin
        m_age[c] = 0;
      end
      if (j[c] && !dec) begin
        if (m_pend[c] == PMAX) m_ovf = 1;
        else m_pend[c]++;
      end else if (!j[c] && dec) m_pend[c]--;
    end
  endfunction

  function automatic bit m_busy();
    bit b;
    b = 0;
    for (int c = 0; c < 3; c++)
      if (m_pend[c] > 0 || m_age[c] >= 0 || m_t + 1 < m_ready[c]) b = 1;
    return b;
  endfunction

  // amode: 0 = a from caller, 1 = priority edge-detect arbiter (grant one
  // cycle after the rising request), 2 = always grant (a = r), 3 = silent,
  // 4 = random stray grants
  int amode = 0;
  bit [2:0] arb_a = 0, r_prev = 0;
  int cyc_n = 0, cnt_done[3], cnt_err[3], cnt_rise[3];
  int done1_t[$];

  task automatic clr_counts();
    for (int c = 0; c < 3; c++) begin cnt_done[c] = 0; cnt_err[c] = 0; cnt_rise[c] = 0; end
    done1_t.delete();
  endtask

  task automatic cyc(input bit [2:0] j, input bit [2:0] af);
    bit [2:0] a, rb, rise, rn, dn, en;
    @(negedge clk);
    rb = {r3, r2, r1};
    case (amode)
      1:       a = arb_a;
      2:       a = rb;
      3:       a = 3'b000;
      4:       a = {($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      default: a = af;
    endcase
    {job3, job2, job1} = j;
    {a3, a2, a1} = a;
    @(posedge clk);
    cyc_n++;
    model_step(j, a);
    rise = rb & ~r_prev;
    arb_a = rise[0] ? 3'b001 : rise[1] ? 3'b010 : rise[2] ? 3'b100 : 3'b000;
    r_prev = rb;
    #1;
    rn = {r3, r2, r1}; dn = {done3, done2, done1}; en = {err3, err2, err1};
    for (int c = 0; c < 3; c++) begin
      if (dn[c]) cnt_done[c]++;
      if (en[c]) cnt_err[c]++;
      if (rn[c] && !rb[c]) cnt_rise[c]++;
    end
    if (dn[0]) done1_t.push_back(cyc_n);
    check("r",    rn, {m_age[2] >= 0, m_age[1] >= 0, m_age[0] >= 0});
    check("done", dn, {m_done[2], m_done[1], m_done[0]});
    check("err",  en, {m_err[2], m_err[1], m_err[0]});
    check("pend1", pend1, m_pend[0]);
    check("pend2", pend2, m_pend[1]);
    check("pend3", pend3, m_pend[2]);
    check("busy", busy, m_busy());
    check("ovf",  ovf, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 3'b000);
  endtask

  typedef struct {
    bit [2:0] job; bit [2:0] a;
    bit [2:0] r;   bit [2:0] done; int pend1; bit busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // inputs/expectations per cycle; single job, stray grant, job+done overlap
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 1, 1};
    tbl[1]  = '{3'b000, 3'b000, 3'b001, 3'b000, 1, 1};
    tbl[2]  = '{3'b000, 3'b000, 3'b001, 3'b000, 1, 1};
    tbl[3]  = '{3'b000, 3'b001, 3'b000, 3'b001, 0, 1};
    tbl[4]  = '{3'b000, 3'b000, 3'b000, 3'b000, 0, 0};
    tbl[5]  = '{3'b000, 3'b001, 3'b000, 3'b000, 0, 0};
    tbl[6]  = '{3'b001, 3'b000, 3'b000, 3'b000, 1, 1};
    tbl[7]  = '{3'b001, 3'b000, 3'b001, 3'b000, 2, 1};
    tbl[8]  = '{3'b000, 3'b001, 3'b000, 3'b001, 1, 1};
    tbl[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1, 1};
    tbl[10] = '{3'b000, 3'b000, 3'b001, 3'b000, 1, 1};
    tbl[11] = '{3'b001, 3'b001, 3'b000, 3'b001, 1, 1};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 3'b000, 1, 1};
    tbl[13] = '{3'b000, 3'b000, 3'b001, 3'b000, 1, 1};
    tbl[14] = '{3'b000, 3'b001, 3'b000, 3'b001, 0, 1};
    tbl[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 0, 0};

    rstn = 1'b0;
    {job3, job2, job1} = 3'b000;
    {a3, a2, a1} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_r", {r3, r2, r1}, 0);
    check("rst_done_err", {done3, done2, done1, err3, err2, err1}, 0);
    check("rst_pend", {pend3, pend2, pend1}, 0);
    check("rst_busy_ovf", {busy, ovf}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Vector table
    amode = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].job, tbl[i].a);
      check($sformatf("tbl%0d_r", i), {r3, r2, r1}, tbl[i].r);
      check($sformatf("tbl%0d_done", i), {done3, done2, done1}, tbl[i].done);
      check($sformatf("tbl%0d_pend1", i), pend1, tbl[i].pend1);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end

    // Collision: ch1 wins, ch2 times out once and is granted on its retry
    amode = 1; clr_counts();
    cyc(3'b011, 3'b000);
    idle(20);
    check("coll_done1", cnt_done[0], 1);
    check("coll_done2", cnt_done[1], 1);
    check("coll_err2", cnt_err[1], 0);
    check("coll_rise2", cnt_rise[1], 2);

    // No grant on ch3: four windows, then the job is discarded
    amode = 3; clr_counts();
    cyc(3'b100, 3'b000);
    idle(30);
    check("nog_rise3", cnt_rise[2], MAX_RETRY + 1);
    check("nog_err3", cnt_err[2], 1);
    check("nog_done3", cnt_done[2], 0);
    check("nog_pend3", pend3, 0);

    // Burst with an always-granting arbiter: dones every 3 cycles
    amode = 2; clr_counts();
    for (int i = 0; i < 5; i++) cyc(3'b001, 3'b000);
    idle(20);
    check("burst_done1", cnt_done[0], 5);
    check("burst_rise1", cnt_rise[0], 5);
    for (int i = 1; i < done1_t.size(); i++)
      check($sformatf("burst_gap%0d", i), done1_t[i] - done1_t[i-1], 3);

    // Saturation: silent arbiter, one job more than the counter holds
    amode = 3; clr_counts();
    for (int i = 0; i < PMAX; i++) cyc(3'b010, 3'b000);
    check("sat_pend2", pend2, PMAX);
    check("sat_ovf_pre", ovf, 0);
    cyc(3'b010, 3'b000);
    check("sat_pend2_hold", pend2, PMAX);
    check("sat_ovf", ovf, 1);
    // jobs overlapping grants keep the count steady
    amode = 2;
    for (int i = 0; i < 12; i++) cyc(3'b010, 3'b000);
    idle(4);

    // Reset while ch1 is requesting with two jobs queued
    amode = 3; clr_counts();
    cyc(3'b001, 3'b000);
    cyc(3'b001, 3'b000);
    check("mid_r1", r1, 1);
    check("mid_pend1", pend1, 2);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_r1", r1, 0);
    check("arst_pend1", pend1, 0);
    check("arst_ovf", ovf, 0);
    {job3, job2, job1} = 3'b000;
    model_reset();
    r_prev = 0; arb_a = 0;
    @(negedge clk);
    rstn = 1'b1;
    amode = 4;
    idle(12);
    check("post_done", cnt_done[0] + cnt_done[1] + cnt_done[2], 0);
    check("post_err", cnt_err[0] + cnt_err[1] + cnt_err[2], 0);

    // Randomized traffic with mixed arbiter behaviours
    for (int blk = 0; blk < 12; blk++) begin
      amode = (blk % 3 == 0) ? 4 : (blk % 3 == 1) ? 1 : 2;
      for (int i = 0; i < 120; i++)
        cyc({($urandom_range(4) == 0), ($urandom_range(4) == 0), ($urandom_range(3) == 0)}, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
